// File: rtl/piso_shift_reg_pkg.sv
// Shared types and helpers for the word-serial shift-register family.
// Holds the PISO state encoding and the beat-counter width rule.
package piso_shift_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // A mod-n counter still needs one bit when n == 1.
  function automatic int cnt_width(input int n);
    int w;
    w = (n <= 1) ? 0 : $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_beat_counter.sv
// Mod-SIZE beat counter: cleared by rst or load, advanced by accepted beats.
// tc flags the last word of the vector currently being unloaded.
module piso_beat_counter
  import piso_shift_reg_pkg::*;
#(
  parameter int SIZE = 3,
  parameter int CW   = cnt_width(SIZE)
) (
  input  logic          clk,
  input  logic          global_rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic          beat,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  assign tc = (cnt == LAST);

  // load has priority over beat so a last-beat reload restarts at word 0.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n)  cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (load)      cnt <= '0;
    else if (beat)      cnt <= tc ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out word shifter with valid/ready on both sides.
// Optional out_last marker is built when PISO_LAST_EN is defined.
module piso_shift_reg
  import piso_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SIZE  = 3
) (
  input  logic                    clk,
  input  logic                    global_rst_n,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [WIDTH*SIZE-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef PISO_LAST_EN
  , output logic                  out_last
`endif
);

  localparam int CW = cnt_width(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  piso_state_e state_q, state_d;

  logic [SIZE-1:0][WIDTH-1:0] in_words;
  logic [SIZE-1:0][WIDTH-1:0] buffer;
  logic [CW-1:0]              cnt;
  logic [CW-1:0]              nxt_idx;
  logic [WIDTH-1:0]           nxt_word;
  logic                       tc;
  logic                       load;
  logic                       beat;

  assign in_words = in_data;
  assign load     = ce & in_valid & in_ready;
  assign beat     = ce & out_valid & out_ready;

  piso_beat_counter #(.SIZE(SIZE), .CW(CW)) u_cnt (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .clr          (rst),
    .load         (load),
    .beat         (beat),
    .cnt          (cnt),
    .tc           (tc)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) state_q <= IDLE;
    else if (rst)      state_q <= IDLE;
    else               state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (load)             state_d = SHIFT;
    else if (beat && tc)  state_d = IDLE;
  end

  // FSM: outputs; in_ready lets a new vector load during the last beat.
  always_comb begin
    out_valid = (state_q == SHIFT);
    in_ready  = ce & ((state_q == IDLE) |
                      ((state_q == SHIFT) & tc & out_ready));
  end

  // Next word index; only consulted when the current word is not the last.
  assign nxt_idx = tc ? '0 : cnt + 1'b1;

  // Compare-based mux keeps the select inside 0..SIZE-1 for any SIZE.
  always_comb begin
    nxt_word = '0;
    for (int k = 0; k < SIZE; k++)
      if (nxt_idx == CW'(k)) nxt_word = buffer[k];
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n)  buffer <= '0;
    else if (rst)       buffer <= '0;
    else if (load)      buffer <= in_words;
  end

  // Last beat without reload leaves out_data holding the final word.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n)        out_data <= '0;
    else if (rst)             out_data <= '0;
    else if (load)            out_data <= in_words[0];
    else if (beat && !tc)     out_data <= nxt_word;
  end

`ifdef PISO_LAST_EN
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n)        out_last <= 1'b0;
    else if (rst)             out_last <= 1'b0;
    else if (load)            out_last <= (SIZE == 1);
    else if (beat && !tc)     out_last <= (nxt_idx == LAST);
    else if (beat)            out_last <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: SIZE=3 vector table plus SIZE=1 and
// asynchronous-reset sequences; out_last is checked when PISO_LAST_EN is set.
module tb_piso_shift_reg;

  logic        clk = 1'b0;
  logic        global_rst_n;
  logic        rst, ce;
  logic [23:0] in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;

  logic [7:0]  s1_in_data;
  logic        s1_in_valid, s1_in_ready;
  logic [7:0]  s1_out_data;
  logic        s1_out_valid, s1_out_ready;
`ifdef PISO_LAST_EN
  logic        out_last, s1_out_last;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(8), .SIZE(3)) u_dut (
    .clk(clk), .global_rst_n(global_rst_n), .rst(rst), .ce(ce),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef PISO_LAST_EN
    , .out_last(out_last)
`endif
  );

  piso_shift_reg #(.WIDTH(8), .SIZE(1)) u_dut1 (
    .clk(clk), .global_rst_n(global_rst_n), .rst(rst), .ce(ce),
    .in_data(s1_in_data), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .out_data(s1_out_data), .out_valid(s1_out_valid), .out_ready(s1_out_ready)
`ifdef PISO_LAST_EN
    , .out_last(s1_out_last)
`endif
  );

  typedef struct {
    logic        rst, ce, iv;
    logic [23:0] d;
    logic        ordy;
    logic        ir;    // in_ready before the edge
    logic        ov;    // out_valid after the edge
    logic [7:0]  od;    // out_data after the edge
    logic        lst;   // out_last after the edge
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; ce = v.ce; in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
    #1 chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.ir));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.ov));
    chk($sformatf("v%0d out_data", idx), 32'(out_data), 32'(v.od));
`ifdef PISO_LAST_EN
    chk($sformatf("v%0d out_last", idx), 32'(out_last), 32'(v.lst));
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst ce iv data ordy | ir ov od lst
    vt.push_back('{0,1,1,24'h332211,1, 1,1,8'h11,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h22,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h33,1});
    vt.push_back('{0,1,0,24'h0,     1, 1,0,8'h33,0});
    vt.push_back('{0,1,0,24'h0,     1, 1,0,8'h33,0});
    vt.push_back('{0,1,1,24'h332211,1, 1,1,8'h11,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h22,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h33,1});
    vt.push_back('{0,1,1,24'h665544,1, 1,1,8'h44,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h55,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h66,1});
    vt.push_back('{0,1,0,24'h0,     1, 1,0,8'h66,0});
    vt.push_back('{0,1,1,24'h332211,1, 1,1,8'h11,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h22,0});
    for (int i = 0; i < 4; i++)
      vt.push_back('{0,1,1,24'hEEDDCC,0, 0,1,8'h22,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h33,1});
    vt.push_back('{0,1,1,24'h998877,1, 1,1,8'h77,0});
    vt.push_back('{0,0,1,24'hEEDDCC,1, 0,1,8'h77,0});
    vt.push_back('{0,0,1,24'hEEDDCC,1, 0,1,8'h77,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h88,0});
    vt.push_back('{0,1,0,24'h0,     1, 0,1,8'h99,1});
    vt.push_back('{0,1,0,24'h0,     0, 0,1,8'h99,1});
    vt.push_back('{0,1,0,24'h0,     1, 1,0,8'h99,0});
    vt.push_back('{0,1,1,24'h332211,1, 1,1,8'h11,0});
    vt.push_back('{1,1,0,24'h0,     1, 0,0,8'h00,0});
    vt.push_back('{0,0,0,24'h0,     1, 0,0,8'h00,0});
    vt.push_back('{0,1,0,24'h0,     1, 1,0,8'h00,0});
    vt.push_back('{0,1,1,24'h332211,1, 1,1,8'h11,0});
    vt.push_back('{1,0,0,24'h0,     1, 0,0,8'h00,0});

    global_rst_n = 1'b0; rst = 1'b0; ce = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s1_in_valid = 1'b0; s1_in_data = '0; s1_out_ready = 1'b0;

    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset in_ready ce=1", 32'(in_ready), 32'd1);
    ce = 1'b0;
    #1 chk("reset in_ready ce=0", 32'(in_ready), 32'd0);
`ifdef PISO_LAST_EN
    chk("reset out_last", 32'(out_last), 32'd0);
`endif
    ce = 1'b1;
    @(negedge clk);
    global_rst_n = 1'b1;

    foreach (vt[i]) step(vt[i], i);

    // Asynchronous reset in the middle of a vector, away from any edge.
    step('{0,1,1,24'h332211,1, 1,1,8'h11,0}, 100);
    step('{0,1,0,24'h0,     1, 0,1,8'h22,0}, 101);
    #2 global_rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async out_data", 32'(out_data), 32'd0);
    chk("async in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    global_rst_n = 1'b1;
    step('{0,1,1,24'h665544,1, 1,1,8'h44,0}, 102);
    step('{0,1,0,24'h0,     1, 0,1,8'h55,0}, 103);

    // SIZE=1: every beat is the last beat; reload during a beat.
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    s1_in_data = 8'hA5; s1_in_valid = 1'b1; s1_out_ready = 1'b1;
    #1 chk("s1 in_ready idle", 32'(s1_in_ready), 32'd1);
    @(posedge clk); #1;
    chk("s1 out_valid load", 32'(s1_out_valid), 32'd1);
    chk("s1 out_data load", 32'(s1_out_data), 32'hA5);
`ifdef PISO_LAST_EN
    chk("s1 out_last load", 32'(s1_out_last), 32'd1);
`endif
    @(negedge clk);
    s1_in_data = 8'h5A; s1_in_valid = 1'b1;
    #1 chk("s1 in_ready last beat", 32'(s1_in_ready), 32'd1);
    @(posedge clk); #1;
    chk("s1 out_valid reload", 32'(s1_out_valid), 32'd1);
    chk("s1 out_data reload", 32'(s1_out_data), 32'h5A);
    @(negedge clk);
    s1_in_valid = 1'b0; s1_out_ready = 1'b0;
    #1 chk("s1 in_ready stalled", 32'(s1_in_ready), 32'd0);
    @(posedge clk); #1;
    chk("s1 out_data stalled", 32'(s1_out_data), 32'h5A);
    @(negedge clk);
    s1_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("s1 out_valid drain", 32'(s1_out_valid), 32'd0);
    chk("s1 out_data drain", 32'(s1_out_data), 32'h5A);
`ifdef PISO_LAST_EN
    chk("s1 out_last drain", 32'(s1_out_last), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
